// File: rtl/avgpool_sequencer.sv
// rtl/avgpool_sequencer.sv - streaming 2x2 average-pooling sequencer with half-width line buffer
//
// Purpose: accepts a row-major IMG_W x IMG_H feature map. It sums each
// non-overlapping 2x2 window and emits the window average in row-major order.
// Optional build macro: AVGPOOL_ROUND_EN rounds to nearest with ties toward
// +inf. When the macro is undefined, the result is the floor (plain
// arithmetic shift).
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      begins a frame; only looked at in IDLE
//   busy       high while a frame is in progress (RUN or FLUSH)
//   done       one-cycle pulse when the last pooled output is accepted
//   in_data    input pixel, signed Q6.10
//   in_valid   in_data is valid
//   in_ready   block can accept in_data this cycle
//   out_data   pooled pixel
//   out_valid  out_data is valid
//   out_ready  downstream accepts out_data
module avgpool_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int LW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
    localparam int PW = DATA_WIDTH + 1;
    localparam int SW = DATA_WIDTH + 2;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic [DATA_WIDTH-1:0]   hreg_q, hreg_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;

    // One horizontal pair sum per output column, carried from the even row
    // to the odd row. Never read before written within a frame, so no reset.
    logic [PW-1:0]           linebuf_q [IMG_W/2];
    logic                    lb_we;
    logic [LW-1:0]           lb_idx;
    logic [PW-1:0]           lb_rd;

    logic                    in_fire;
    logic [PW-1:0]           pair;
    logic [SW-1:0]           sum;
    logic [SW-1:0]           rounded;
    logic [1:0]              unused_lsbs;

    assign busy      = (state_q != S_IDLE);
    // Single-entry output stage: a new pixel may enter only if the pending
    // result is empty or is being drained this same cycle.
    assign in_ready  = (state_q == S_RUN) && (!out_valid_q || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    assign lb_idx = LW'(col_q >> 1);
    assign lb_rd  = linebuf_q[lb_idx];
    assign pair   = {hreg_q[DATA_WIDTH-1], hreg_q} + {in_data[DATA_WIDTH-1], in_data};
    assign sum    = {pair[PW-1], pair} + {lb_rd[PW-1], lb_rd};

`ifdef AVGPOOL_ROUND_EN
    assign rounded = sum + SW'(2);
`else
    assign rounded = sum;
`endif

    // Dropping the two LSBs of the 18-bit sum is the arithmetic >>> 2,
    // already truncated to DATA_WIDTH; the average cannot exceed the range.
    assign unused_lsbs = rounded[1:0];

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        hreg_d      = hreg_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        lb_we       = 1'b0;
        done        = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_RUN: begin
                if (in_fire) begin
                    if (!col_q[0]) begin
                        hreg_d = in_data;
                    end else if (!row_q[0]) begin
                        lb_we = 1'b1;
                    end else begin
                        out_data_d  = rounded[DATA_WIDTH+1:2];
                        out_valid_d = 1'b1;
                    end

                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
                        if (row_q == ROW_LAST) begin
                            state_d = S_FLUSH;
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (out_valid_q && out_ready) begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            hreg_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            hreg_q      <= hreg_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[lb_idx] <= pair;
        end
    end

endmodule
